uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares the single UART transmit path between two byte sources: requester 0 is the CPU store path and requester 1 is the hardware echo/loopback path. Each source has a private FIFO. A round-robin scheduler drains the FIFOs into the UART sender through a start/status handshake. The block sits between the peripheral register file and the UART sender, in the processor clock domain; any status synchronisation from the sender's baud domain happens upstream of `tx_status`.

## Interface
- `FIFO_DEPTH`, 4 — entries per requester FIFO; power of two, 2..16.
- `ACK_TIMEOUT`, 15 — cycles to wait for the sender to leave idle after `tx_en`; range 1..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester presents a byte.
- `req0_data` / `req1_data`  in  8  byte to transmit.
- `req0_ready` / `req1_ready`  out  1  FIFO not full; the byte is accepted when valid && ready.
- `tx_status`  in  1  sender idle (1) / sending (0).
- `tx_en`  out  1  one-cycle start pulse to the sender.
- `tx_data`  out  8  byte to the sender; held stable from `tx_en` until the byte completes.
- `grant`  out  1  requester owning the current or last byte.
- `busy`  out  1  FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when a byte completes.
- `err`  out  1  sticky: a start timed out; cleared only by reset.

## Operation
- **FIFOs.**
  - Each FIFO has a count register of width log2(FIFO_DEPTH)+1, with read/write pointers that wrap modulo FIFO_DEPTH.
  - `reqN_ready` = !(countN == FIFO_DEPTH). It is computed from registered state only.
  - Push and pop on the same FIFO in the same cycle: count is unchanged and pointers advance. This is legal only when the FIFO is non-empty.
  - When the FIFO is full, a push is refused even if a pop happens in the same cycle.
- **FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Condition: `tx_status`=1 and at least one FIFO is non-empty.
  - Selection: the non-empty FIFO other than `last` is chosen if possible; otherwise the only non-empty one.
  - Actions: pop the chosen FIFO, load `tx_data`, set `grant`, go to LAUNCH.
- **LAUNCH**
  - Assert `tx_en` for exactly one cycle.
  - Clear the timeout counter.
  - Go to WAIT_BUSY.
- **WAIT_BUSY**
  - `tx_status`=0: go to WAIT_DONE.
  - Otherwise increment the counter. When counter == ACK_TIMEOUT: set `err`, discard the byte, update `last`, go to IDLE. `done` does not pulse.
- **WAIT_DONE**
  - `tx_status`=1: pulse `done`, set `last` = `grant`, go to IDLE.
- **Timer.** The timeout counter is 8 bits and saturates. It runs only in WAIT_BUSY.
- **Reset values.**
  - FIFOs empty; `req0_ready` = `req1_ready` = 1.
  - `tx_en`=0, `tx_data`=0, `grant`=0, `busy`=0, `done`=0, `err`=0.
  - `last`=1, so requester 0 wins first.
  - FSM in IDLE.
- **Reset mid-operation.** Reset asserted in any state returns to IDLE immediately, empties both FIFOs and drops the in-flight byte. `tx_en` falls asynchronously.

## Timing
- Push in cycle N → byte is in the FIFO at edge N+1.
- Earliest IDLE pop is in cycle N+1. `tx_en` is high in cycle N+2.
- Back-to-back bytes: `done` in cycle M → next pop in cycle M+1 (IDLE), next `tx_en` in cycle M+2.
- Minimum per-byte overhead: 3 cycles beyond the sender's busy time.
- `tx_data` changes only on the IDLE→LAUNCH edge.
- `busy` is registered and is high in LAUNCH, WAIT_BUSY and WAIT_DONE.
- `done` and `tx_en` are never high in the same cycle.
- If `tx_status` drops in the same cycle that `tx_en` is asserted, WAIT_BUSY sees it on the next cycle and moves on; there is no timeout.

## Configuration
- `UART_SCHED_PRIO_EN` defined:
  - IDLE always selects FIFO 0 when it is non-empty. FIFO 1 is served only when FIFO 0 is empty.
  - `last` is not implemented.
- Undefined: round-robin as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** assert reset mid-WAIT_DONE → all outputs at reset values, both readies 1, `busy`=0 the same cycle.
- **Round-robin:** push 0x11, 0x22 on requester 0 and 0xA1, 0xA2 on requester 1 in one cycle; sender model busy 10 cycles → `tx_data` order 0x11, 0xA1, 0x22, 0xA2, with four `done` pulses.
- **Full FIFO:** with the sender held busy, push 5 bytes on requester 0 with FIFO_DEPTH=4 → `req0_ready`=0 after the 4th accept; the 5th byte is not taken; one pop restores ready next cycle.
- **Timeout:** hold `tx_status`=1 after `tx_en` → `err`=1 after 15 cycles in WAIT_BUSY, no `done`, FSM back in IDLE, next byte launched.
- **Priority build:** with `UART_SCHED_PRIO_EN`, keep FIFO 0 non-empty continuously → requester 1 never granted until FIFO 0 drains.
- **Pointer wrap:** stream 20 bytes (0x00..0x13) through requester 1 → output sequence exact and in order.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Requester and sender-side signals of uart_tx_scheduler.
// The slave modport is the scheduler's view, the master modport is the surrounding logic's view.
interface uart_tx_scheduler_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       tx_status;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       grant;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_status,
        input  req0_ready, req1_ready, tx_en, tx_data, grant, busy, done, err
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_status,
        output req0_ready, req1_ready, tx_en, tx_data, grant, busy, done, err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one UART sender between two byte sources, each with a private FIFO, via a start/status handshake.
// Build option UART_SCHED_PRIO_EN: requester 0 always wins instead of round-robin.
//
// state     | meaning
// IDLE      | wait for sender idle and a non-empty FIFO, then pop and load tx_data
// LAUNCH    | tx_en pulse, timeout counter cleared
// WAIT_BUSY | wait for sender to leave idle, timeout after ACK_TIMEOUT cycles
// WAIT_DONE | wait for sender to return to idle, done pulse
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input logic                clk,
    input logic                reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [7:0]    TIMEOUT_TC = 8'(ACK_TIMEOUT);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]    state;
    logic [7:0]    mem   [2][FIFO_DEPTH];
    logic [PW-1:0] wptr  [2];
    logic [PW-1:0] rptr  [2];
    logic [CW-1:0] count [2];
    logic [7:0]    wdata [2];
    logic [1:0]    valid, ready, nonempty, push, pop;
    logic          start, sel, timed_out;
    logic [7:0]    tmr, tmr_next;
    logic          tx_en_q, grant_q, busy_q, err_q;
    logic [7:0]    tx_data_q;

    assign valid    = {bus.req1_valid, bus.req0_valid};
    assign wdata[0] = bus.req0_data;
    assign wdata[1] = bus.req1_data;

    always_comb begin
        ready    = '0;
        nonempty = '0;
        for (int i = 0; i < 2; i++) begin
            ready[i]    = count[i] != FULL_COUNT;
            nonempty[i] = count[i] != '0;
        end
    end

    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign push = valid & ready;
    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];

`ifdef UART_SCHED_PRIO_EN
    assign sel = !nonempty[0];
`else
    logic last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last <= 1'b1;
        else if (bus.done || timed_out)
            last <= grant_q;
    end

    assign sel = (nonempty[0] && nonempty[1]) ? !last : nonempty[1];
`endif

    assign start     = (state == IDLE) && bus.tx_status && (nonempty != 2'b00);
    assign pop       = start ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign tmr_next  = (tmr == 8'hFF) ? tmr : tmr + 8'd1;
    assign timed_out = (state == WAIT_BUSY) && bus.tx_status && (tmr_next == TIMEOUT_TC);

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (push[i])
                mem[i][wptr[i]] <= wdata[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i])
                    wptr[i] <= wptr[i] + 1'b1;
                if (pop[i])
                    rptr[i] <= rptr[i] + 1'b1;
                if (push[i] && !pop[i])
                    count[i] <= count[i] + 1'b1;
                else if (pop[i] && !push[i])
                    count[i] <= count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            tmr       <= 8'h00;
        end else begin
            tx_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_data_q <= mem[sel][rptr[sel]];
                        grant_q   <= sel;
                        tx_en_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmr   <= 8'h00;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!bus.tx_status) begin
                        state <= WAIT_DONE;
                    end else begin
                        tmr <= tmr_next;
                        if (timed_out) begin
                            err_q  <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_status) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // done is combinational so the next pop lands in the cycle right after it.
    assign bus.done    = (state == WAIT_DONE) && bus.tx_status;
    assign bus.tx_en   = tx_en_q;
    assign bus.tx_data = tx_data_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: vector table for FIFO fill, scoreboard of expected launches.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if bus_if();

    uart_tx_scheduler #(.FIFO_DEPTH(4), .ACK_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic [7:0] data;
        logic       grant;
    } exp_t;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       rdy0;
        logic       rdy1;
    } vec_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   done_cnt  = 0;
    int   busy_left = 0;
    int   busy_len  = 3;
    bit   sender_ack = 1'b1;
    bit   force_busy = 1'b0;
    bit   overlap    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Sender model: samples outputs mid-cycle, moves tx_status just after the rising edge.
    initial begin : sender
        exp_t e;
        bus_if.tx_status = 1'b1;
        forever begin
            @(negedge clk);
            if (bus_if.tx_en && bus_if.done) overlap = 1'b1;
            if (bus_if.done) done_cnt++;
            if (bus_if.tx_en) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_launch: got data 0x%0h grant %0d, expected no launch",
                             bus_if.tx_data, bus_if.grant);
                end else begin
                    e = exp_q.pop_front();
                    chk("launch_data", 32'(bus_if.tx_data), 32'(e.data));
                    chk("launch_grant", 32'(bus_if.grant), 32'(e.grant));
                end
            end
            if (!reset) busy_left = 0;
            else if (busy_left > 0) busy_left--;
            else if (bus_if.tx_en && sender_ack) busy_left = busy_len;
            @(posedge clk);
            #1;
            bus_if.tx_status = force_busy ? 1'b0 : (busy_left == 0);
        end
    end

    task automatic drive_cycle(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        @(negedge clk);
        bus_if.req0_valid = v0;
        bus_if.req0_data  = d0;
        bus_if.req1_valid = v1;
        bus_if.req1_data  = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.req0_valid = 1'b0;
        bus_if.req1_valid = 1'b0;
    endtask

    task automatic expect_launch(input logic [7:0] data, input logic grant);
        exp_q.push_back('{data: data, grant: grant});
    endtask

    task automatic stream(input bit port, input logic [7:0] base, input int n, output int acc);
        int   guard;
        logic rdy;
        guard = 0;
        acc   = 0;
        while (acc < n && guard < 500) begin
            @(negedge clk);
            if (port) begin
                bus_if.req1_valid = 1'b1;
                bus_if.req1_data  = base + 8'(acc);
                rdy = bus_if.req1_ready;
            end else begin
                bus_if.req0_valid = 1'b1;
                bus_if.req0_data  = base + 8'(acc);
                rdy = bus_if.req0_ready;
            end
            @(posedge clk);
            if (rdy) acc++;
            guard++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic wait_tx_en(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.tx_en && n < 100);
        chk(name, 32'(bus_if.tx_en), 1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_if.busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 2000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : main
        vec_t vt[5];
        int   d0, k, acc;

        bus_if.req0_valid = 1'b0;
        bus_if.req0_data  = 8'h00;
        bus_if.req1_valid = 1'b0;
        bus_if.req1_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_en",   32'(bus_if.tx_en), 0);
        chk("rst_tx_data", 32'(bus_if.tx_data), 0);
        chk("rst_grant",   32'(bus_if.grant), 0);
        chk("rst_busy",    32'(bus_if.busy), 0);
        chk("rst_done",    32'(bus_if.done), 0);
        chk("rst_err",     32'(bus_if.err), 0);
        chk("rst_ready0",  32'(bus_if.req0_ready), 1);
        chk("rst_ready1",  32'(bus_if.req1_ready), 1);
        force_busy = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Full FIFO: sender held busy so nothing pops; fifth byte on requester 0 is refused
        vt[0] = '{v0: 1'b1, d0: 8'h10, v1: 1'b0, d1: 8'h00, rdy0: 1'b1, rdy1: 1'b1};
        vt[1] = '{v0: 1'b1, d0: 8'h11, v1: 1'b1, d1: 8'hB0, rdy0: 1'b1, rdy1: 1'b1};
        vt[2] = '{v0: 1'b1, d0: 8'h12, v1: 1'b0, d1: 8'h00, rdy0: 1'b1, rdy1: 1'b1};
        vt[3] = '{v0: 1'b1, d0: 8'h13, v1: 1'b0, d1: 8'h00, rdy0: 1'b0, rdy1: 1'b1};
        vt[4] = '{v0: 1'b1, d0: 8'h14, v1: 1'b0, d1: 8'h00, rdy0: 1'b0, rdy1: 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(vt[i].v0, vt[i].d0, vt[i].v1, vt[i].d1);
            chk($sformatf("fill_ready0_%0d", i), 32'(bus_if.req0_ready), 32'(vt[i].rdy0));
            chk($sformatf("fill_ready1_%0d", i), 32'(bus_if.req1_ready), 32'(vt[i].rdy1));
        end
        idle_inputs();
`ifdef UART_SCHED_PRIO_EN
        expect_launch(8'h10, 1'b0);
        expect_launch(8'h11, 1'b0);
        expect_launch(8'h12, 1'b0);
        expect_launch(8'h13, 1'b0);
        expect_launch(8'hB0, 1'b1);
`else
        expect_launch(8'h10, 1'b0);
        expect_launch(8'hB0, 1'b1);
        expect_launch(8'h11, 1'b0);
        expect_launch(8'h12, 1'b0);
        expect_launch(8'h13, 1'b0);
`endif
        d0 = done_cnt;
        @(negedge clk);
        force_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("ready0_still_full", 32'(bus_if.req0_ready), 0);
        @(posedge clk);
        #1;
        chk("ready0_after_pop", 32'(bus_if.req0_ready), 1);
        wait_drain("fill_drain");
        chk("fill_done_count", done_cnt - d0, 5);

        // Timeout: sender never leaves idle; second byte queued during WAIT_BUSY
        sender_ack = 1'b0;
        d0 = done_cnt;
        expect_launch(8'h55, 1'b0);
        expect_launch(8'h66, 1'b1);
        drive_cycle(1'b1, 8'h55, 1'b0, 8'h00);
        idle_inputs();
        wait_tx_en("to_launch_seen");
        k = 0;
        while (!bus_if.err && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus_if.req1_valid = 1'b1;
                bus_if.req1_data  = 8'h66;
            end else if (k == 2) begin
                bus_if.req1_valid = 1'b0;
            end
        end
        chk("to_err_latency", k, 16);
        chk("to_busy_idle", 32'(bus_if.busy), 0);
        chk("to_no_done", done_cnt - d0, 0);
        sender_ack = 1'b1;
        wait_drain("to_drain");
        chk("to_next_done", done_cnt - d0, 1);
        chk("to_err_sticky", 32'(bus_if.err), 1);

        // Pointer wrap: 20 bytes through requester 1
        busy_len = 2;
        for (int i = 0; i < 20; i++) expect_launch(8'(i), 1'b1);
        stream(1'b1, 8'h00, 20, acc);
        chk("wrap_accepted", acc, 20);
        wait_drain("wrap_drain");

        // Reset in WAIT_DONE with two bytes still queued
        busy_len = 10;
        expect_launch(8'h77, 1'b0);
        drive_cycle(1'b1, 8'h77, 1'b0, 8'h00);
        idle_inputs();
        wait_tx_en("mid_launch_seen");
        drive_cycle(1'b1, 8'h78, 1'b0, 8'h00);
        drive_cycle(1'b1, 8'h79, 1'b0, 8'h00);
        idle_inputs();
        @(negedge clk);
        chk("mid_busy_before", 32'(bus_if.busy), 1);
        reset = 1'b0;
        #1;
        chk("mid_tx_en",   32'(bus_if.tx_en), 0);
        chk("mid_tx_data", 32'(bus_if.tx_data), 0);
        chk("mid_grant",   32'(bus_if.grant), 0);
        chk("mid_busy",    32'(bus_if.busy), 0);
        chk("mid_done",    32'(bus_if.done), 0);
        chk("mid_err",     32'(bus_if.err), 0);
        chk("mid_ready0",  32'(bus_if.req0_ready), 1);
        chk("mid_ready1",  32'(bus_if.req1_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        chk("mid_no_done_after", done_cnt - d0, 0);
        chk("mid_idle_after", 32'(bus_if.busy), 0);

        // Round-robin after reset: requester 0 first
        d0 = done_cnt;
`ifdef UART_SCHED_PRIO_EN
        expect_launch(8'h11, 1'b0);
        expect_launch(8'h22, 1'b0);
        expect_launch(8'hA1, 1'b1);
        expect_launch(8'hA2, 1'b1);
`else
        expect_launch(8'h11, 1'b0);
        expect_launch(8'hA1, 1'b1);
        expect_launch(8'h22, 1'b0);
        expect_launch(8'hA2, 1'b1);
`endif
        drive_cycle(1'b1, 8'h11, 1'b1, 8'hA1);
        drive_cycle(1'b1, 8'h22, 1'b1, 8'hA2);
        idle_inputs();
        wait_drain("rr_drain");
        chk("rr_done_count", done_cnt - d0, 4);

        // FIFO 0 kept non-empty while requester 1 waits
        busy_len = 3;
`ifdef UART_SCHED_PRIO_EN
        for (int i = 0; i < 6; i++) expect_launch(8'hC0 + 8'(i), 1'b0);
        expect_launch(8'hB1, 1'b1);
`else
        expect_launch(8'hC0, 1'b0);
        expect_launch(8'hB1, 1'b1);
        for (int i = 1; i < 6; i++) expect_launch(8'hC0 + 8'(i), 1'b0);
`endif
        drive_cycle(1'b1, 8'hC0, 1'b1, 8'hB1);
        bus_if.req1_valid = 1'b0;
        stream(1'b0, 8'hC1, 5, acc);
        chk("prio_accepted", acc, 5);
        wait_drain("prio_drain");

        chk("no_done_tx_en_overlap", 32'(overlap), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
